// File: rtl/axis_glue_pkg.sv
// Shared constants and types for the AXI-Stream width glue blocks.
// Used by axis_width_32_to_16 and axis_skid_buffer.
package axis_glue_pkg;

    localparam int AXIS_WIDE_W   = 32;
    localparam int AXIS_NARROW_W = 16;

    localparam logic [AXIS_NARROW_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [AXIS_NARROW_W-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer, generic width, registered ready.
// Main entry drives the outputs; skid entry absorbs one stalled beat.
module axis_skid_buffer
    import axis_glue_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    skid_state_t r_state;
    skid_state_t w_next;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_ready;
    logic         r_valid;
    logic         w_acc;
    logic         w_xfr;
    logic         w_load_main;
    logic         w_load_skid;
    logic         w_pop_skid;

    assign w_acc = i_valid && r_ready;
    assign w_xfr = r_valid && i_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            EMPTY: if (w_acc) w_next = ONE;
            ONE: begin
                if (w_acc && !w_xfr)
                    w_next = FULL;
                else if (!w_acc && w_xfr)
                    w_next = EMPTY;
            end
            FULL: if (w_xfr) w_next = ONE;
            default: w_next = EMPTY;
        endcase
    end

    assign w_load_main = w_acc &&
        ((r_state == EMPTY) || (r_state == ONE && w_xfr));
    assign w_load_skid = w_acc && (r_state == ONE) && !w_xfr;
    assign w_pop_skid  = w_xfr && (r_state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != FULL);
            r_valid <= (w_next != EMPTY);
            if (w_load_main)
                r_main <= i_data;
            else if (w_pop_skid)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;

endmodule

// File: rtl/axis_width_32_to_16.sv
// 32->16 bit signed AXI-Stream narrowing bridge with overflow accounting.
// Define AXIS_W32_16_SAT_EN to clamp out-of-range words; else truncate.
module axis_width_32_to_16
    import axis_glue_pkg::*;
#(
    parameter int DATA_IN_W  = AXIS_WIDE_W,
    parameter int DATA_OUT_W = AXIS_NARROW_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_IN_W-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_OUT_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  ovf_clr,
    output logic                  ovf_flag,
    output logic [CNT_W-1:0]      ovf_count
);

    logic [DATA_IN_W-DATA_OUT_W:0] w_top;
    logic                          w_ovf;
    logic                          w_acc;
    logic [DATA_OUT_W-1:0]         w_narrow;
    logic [CNT_W-1:0]              w_cnt_base;
    logic                          r_flag;
    logic [CNT_W-1:0]              r_cnt;

    // Sign bit plus every discarded bit must agree for an in-range word.
    assign w_top = s_axis_tdata[DATA_IN_W-1:DATA_OUT_W-1];
    assign w_ovf = !((&w_top) || !(|w_top));
    assign w_acc = s_axis_tvalid && s_axis_tready;

`ifdef AXIS_W32_16_SAT_EN
    always_comb begin
        w_narrow = s_axis_tdata[DATA_OUT_W-1:0];
        if (w_ovf)
            w_narrow = s_axis_tdata[DATA_IN_W-1]
                ? DATA_OUT_W'(SAT_NEG)
                : DATA_OUT_W'(SAT_POS);
    end
`else
    assign w_narrow = s_axis_tdata[DATA_OUT_W-1:0];
`endif

    // Clear takes effect before a same-edge increment.
    assign w_cnt_base = ovf_clr ? '0 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else if (w_acc && w_ovf) begin
            r_flag <= 1'b1;
            r_cnt  <= (&w_cnt_base) ? w_cnt_base
                                    : w_cnt_base + 1'b1;
        end else if (ovf_clr) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign ovf_flag  = r_flag;
    assign ovf_count = r_cnt;

    axis_skid_buffer #(
        .W (DATA_OUT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_narrow),
        .i_valid (s_axis_tvalid),
        .o_ready (s_axis_tready),
        .o_data  (m_axis_tdata),
        .o_valid (m_axis_tvalid),
        .i_ready (m_axis_tready)
    );

endmodule
